// File: rtl/vedic_pkg.sv
// Shared types and sizing for the sequential 2x2-core multiplier.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int STEPS  = 16;

endpackage

// File: rtl/vedic_2x2.sv
// Combinational 2x2 Vedic (Urdhva-Tiryagbhyam) multiplier core.
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic cross_hi;
    logic cross_lo;
    logic carry;

    // Vertical and crosswise partial products combined with half-adder logic.
    always_comb begin
        cross_hi = a[1] & b[0];
        cross_lo = a[0] & b[1];
        carry    = cross_hi & cross_lo;
        p[0]     = a[0] & b[0];
        p[1]     = cross_hi ^ cross_lo;
        p[2]     = (a[1] & b[1]) ^ carry;
        p[3]     = a[1] & b[1] & carry;
    end

endmodule

// File: rtl/vedic_seq_mul8.sv
// 8x8 unsigned multiplier: one 2x2 core reused over 16 steps, shift-accumulate.
module vedic_seq_mul8
    import vedic_pkg::*;
#(
    parameter int OP_W = vedic_pkg::OP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   p,
    output logic                busy
);

    state_t              state;
    state_t              next_state;
    logic [OP_W-1:0]     op_a;
    logic [OP_W-1:0]     op_b;
    logic [PROD_W-1:0]   acc;
    logic [3:0]          step;
    logic                rdy_en;
    logic                accept;
    logic [1:0]          i_idx;
    logic [1:0]          j_idx;
    logic [3:0]          core_p;
    logic [3:0]          shamt;
    logic [PROD_W-1:0]   pp;

    vedic_2x2 u_core (
        .a (op_a[{i_idx, 1'b0} +: 2]),
        .b (op_b[{j_idx, 1'b0} +: 2]),
        .p (core_p)
    );

    // Digit selection and partial-product alignment for the current step.
    always_comb begin
        i_idx  = step[3:2];
        j_idx  = step[1:0];
        shamt  = 4'({i_idx, 1'b0}) + 4'({j_idx, 1'b0});
        pp     = PROD_W'(core_p) << shamt;
        accept = in_valid & in_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        p          = acc;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = rdy_en;
                if (in_valid && rdy_en) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (step == 4'(STEPS - 1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, step counter and accumulator; rdy_en delays in_ready
    // until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            step   <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                op_a <= a;
                op_b <= b;
                acc  <= '0;
                step <= '0;
            end else if (state == RUN) begin
                acc  <= acc + pp;
                step <= step + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vedic_seq_mul8.sv
// Scoreboard bench for vedic_seq_mul8: random and directed operands vs a*b.
module tb_vedic_seq_mul8;

    typedef struct {
        logic [15:0] prod;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_results = 0;
    int unsigned ov_cnt = 0;
    int unsigned ready_mode = 0;
    logic        prev_ov = 1'b0;
    logic        just_popped = 1'b0;

    vedic_seq_mul8 #(.OP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer: 0 = always ready, 1 = random, 2 = ready after 5 stalled cycles
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (ov_cnt >= 5);
        endcase
    end

    // Monitor: compares presented products against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov     = 1'b0;
            just_popped = 1'b0;
            ov_cnt      = 0;
        end else begin
            if (just_popped) begin
                chk("exit_to_idle", {29'd0, out_valid, busy, in_ready}, 32'b001);
                just_popped = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!prev_ov) chk("latency", cyc - exp_q[0].cyc, 32'd16);
                    chk("product", {16'd0, p}, {16'd0, exp_q[0].prod});
                    chk("done_flags", {30'd0, in_ready, busy}, 32'b01);
                    ov_cnt++;
                    if (out_ready) begin
                        if (ready_mode == 2) chk("stall_len", ov_cnt, 32'd6);
                        void'(exp_q.pop_front());
                        n_results++;
                        just_popped = 1'b1;
                        ov_cnt      = 0;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic offer(input logic [7:0] x, input logic [7:0] y);
        int unsigned t;
        exp_t e;
        t = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.prod = 16'(x) * 16'(y);
            e.cyc  = cyc;
            exp_q.push_back(e);
            in_valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            chk("accept_busy", {30'd0, busy, in_ready}, 32'b10);
        end
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            t++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #3;
        chk("reset_outputs", {13'd0, out_valid, in_ready, busy, p}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", {31'd0, in_ready}, 32'd1);

        // Directed corner operands, consumer always ready
        ready_mode = 0;
        offer(8'hFF, 8'hFF); drain();
        offer(8'h00, 8'h5A); drain();
        offer(8'h01, 8'hB7); drain();

        // Consumer stalls 5 cycles
        ready_mode = 2;
        offer(8'h0D, 8'h0B); drain();
        ready_mode = 0;

        // New offer during RUN must be ignored
        offer(8'h37, 8'h9C);
        in_valid = 1'b1;
        a = 8'h12;
        b = 8'h34;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        offer(8'h12, 8'h34); drain();

        // Reset at step 7 aborts the operation
        offer(8'hAA, 8'h55);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_reset_outputs", {13'd0, out_valid, in_ready, busy, p}, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_hold", {13'd0, out_valid, in_ready, busy, p}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_ready_after_edge", {31'd0, in_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        offer(8'hAA, 8'h55); drain();

        // Random regression with random back-pressure
        ready_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            offer(8'($urandom), 8'($urandom));
        end
        drain();

        chk("result_count", n_results, 32'd1007);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vedic_seq_mul8.md
VEDIC_SEQ_MUL8 -- requirements
Module: vedic_seq_mul8

Interface
REQ-001 SHALL have parameter OP_W, default 8, operand width; only 8 is supported, the parameter exists for package alignment.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  8  multiplicand.
REQ-007 SHALL have port b  input  8  multiplier.
REQ-008 SHALL have port out_valid  output  1  product available.
REQ-009 SHALL have port out_ready  input  1  consumer takes product.
REQ-010 SHALL have port p  output  16  unsigned product a*b.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready high only in IDLE; in_valid is ignored in RUN and DONE.
REQ-014 On an accepting edge (in_valid & in_ready), SHALL latch a and b, clear the 16-bit accumulator and the 4-bit step counter, and enter RUN.
REQ-015 In RUN, each cycle SHALL apply a[2i+1:2i] and b[2j+1:2j] to the single 2x2 core, with i = step[3:2] and j = step[1:0].
REQ-016 In RUN, SHALL add the core's 4-bit result, zero-extended and left-shifted by 2*(i+j), to the accumulator.
REQ-017 SHALL increment step each RUN cycle; step 15 is the last, and that edge enters DONE.
REQ-018 Latency: out_valid SHALL rise on the 16th rising edge after the accepting edge; throughput is one product per at least 17 cycles.
REQ-019 p SHALL be the registered accumulator; it SHALL be valid and stable while out_valid is high.
REQ-020 The accumulator SHALL be 16 bits with no overflow, since the maximum product is 0xFE01; no saturation logic is required.
REQ-021 DONE SHALL hold out_valid and p unchanged until out_ready is high, then return to IDLE on that edge.
REQ-022 SHALL NOT accept a new operand pair on the DONE-exit edge; the earliest new accept is the following edge.
REQ-023 out_ready outside DONE SHALL have no effect.
REQ-024 Operand changes on a and b after the accepting edge SHALL NOT affect the result.

Reset
REQ-025 On rst_n low, SHALL asynchronously force state IDLE, step 0, accumulator 0, latched operands 0, out_valid 0, and p 0.
REQ-026 While rst_n is low, in_ready SHALL be 0 and busy SHALL be 0.
REQ-027 On rst_n release, in_ready SHALL be 1 from the first edge after release.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation; no partial product or out_valid pulse SHALL appear after release.

Structure
REQ-029 A shared package vedic_pkg SHALL hold the state enum (IDLE, RUN, DONE), OP_W = 8, PROD_W = 16, and STEPS = 16.
REQ-030 SHALL instantiate exactly one vedic_2x2 sub-module as the combinational core; no other multiplier is permitted.
REQ-031 Partial-product shift and accumulate logic SHALL be local to this module.

Verification
REQ-032 a=0xFF, b=0xFF accepted at edge T0, out_ready held 1 -> out_valid at T16, p=0xFE01, IDLE at T17.
REQ-033 a=0x00, b=0x5A -> p=0x0000 at T16; a=0x01, b=0xB7 -> p=0x00B7 at T16.
REQ-034 a=0x0D, b=0x0B with out_ready low for 5 cycles after out_valid -> p=0x008F stable, in_ready 0 throughout, then exit on the first out_ready edge.
REQ-035 New in_valid with a=0x12, b=0x34 asserted during RUN -> ignored, first result unaffected; re-offered in IDLE -> p=0x03A8.
REQ-036 rst_n pulsed low at step 7 of a=0xAA, b=0x55 -> out_valid never rises; the next op a=0xAA, b=0x55 -> p=0x3872.
REQ-037 A random 1000-operand regression with random out_ready -> every p equals the reference product a*b, with no dropped or duplicated results.
